// File: rtl/frame_draw_scheduler_if.sv
// frame_draw_scheduler_if
// Job-enqueue channel between the game-mode logic (master) and the frame
// draw scheduler (slave). A job is pushed on a clock edge where iJobValid
// and oJobReady are both high.
//   iJobValid  job enqueue request
//   oJobReady  queue not full
//   iJobX/Y    sprite top-left screen position
//   iJobW/H    sprite size (0..63; zero means "skip this job")
//   iJobSrc    ROM select of the sprite image (1..15)
interface frame_draw_scheduler_if;
  logic       iJobValid;
  logic       oJobReady;
  logic [8:0] iJobX;
  logic [7:0] iJobY;
  logic [5:0] iJobW;
  logic [5:0] iJobH;
  logic [3:0] iJobSrc;

  modport master (
    output iJobValid, iJobX, iJobY, iJobW, iJobH, iJobSrc,
    input  oJobReady
  );

  modport slave (
    input  iJobValid, iJobX, iJobY, iJobW, iJobH, iJobSrc,
    output oJobReady
  );
endinterface

// File: rtl/frame_draw_scheduler.sv
// frame_draw_scheduler
// Sequences one VGA frame redraw per vsync falling edge onto the single
// pixel-plot port: the full-screen background first, then every queued
// sprite job. ROM address and screen coordinates are issued together; a
// one-stage pipeline delays x/y/strobe so they line up with the ROM data.
//   clk, iResetn      clock, asynchronous active-low reset
//   iVSync            vertical sync (synchronous to clk)
//   jobBus            job enqueue channel (slave side)
//   oRomSel/oRomAddr  ROM select (0 = background) and read address
//   iRomQ             ROM data, one cycle after the address
//   oX/oY/oColor      plot position and colour
//   oWriteEn          plot strobe
//   oBusy             scheduler not idle
//   oFrameDone        one-cycle pulse at the end of a frame
//   oOverrun          one-cycle pulse for a vsync edge seen while busy
module frame_draw_scheduler #(
  parameter int unsigned SCREEN_W  = 320,
  parameter int unsigned SCREEN_H  = 240,
  parameter int unsigned DEPTH     = 4,
  parameter logic [2:0]  KEY_COLOR = 3'b111
) (
  input  logic                         clk,
  input  logic                         iResetn,
  input  logic                         iVSync,
  frame_draw_scheduler_if.slave        jobBus,
  output logic [3:0]                   oRomSel,
  output logic [16:0]                  oRomAddr,
  input  logic [2:0]                   iRomQ,
  output logic [8:0]                   oX,
  output logic [7:0]                   oY,
  output logic [2:0]                   oColor,
  output logic                         oWriteEn,
  output logic                         oBusy,
  output logic                         oFrameDone,
  output logic                         oOverrun
);
  localparam int unsigned    PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE    = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [8:0]     LAST_X     = 9'(SCREEN_W - 1);
  localparam logic [7:0]     LAST_Y     = 8'(SCREEN_H - 1);
  localparam logic [9:0]     SCREEN_W_L = 10'(SCREEN_W);
  localparam logic [8:0]     SCREEN_H_L = 9'(SCREEN_H);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BG     = 3'd1,
    S_LOAD   = 3'd2,
    S_SPRITE = 3'd3,
    S_FLUSH  = 3'd4
  } state_t;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [5:0] w;
    logic [5:0] h;
    logic [3:0] src;
  } job_t;

  state_t         state_r, state_nx;
  job_t           fifo_mem_r [DEPTH];
  job_t           head_s, job_in_s;
  logic [PTR_W:0] wr_ptr_r, rd_ptr_r, wr_ptr_nx, rd_ptr_nx;
  logic           fifo_empty_s, full_nx_s, last_one_s, push_s, pop_s;
  logic           vsync_prev_r, vsync_fall_s;
  logic           job_ready_r, busy_r, done_r, overrun_r;
  logic [8:0]     job_x_r;
  logic [7:0]     job_y_r;
  logic [5:0]     job_w_r, job_h_r;
  logic [16:0]    addr_r, addr_nx, addr_step_s;
  logic [8:0]     u_r, u_nx, u_step_s, row_last_s;
  logic [7:0]     v_r, v_nx, v_step_s, col_last_s;
  logic           row_end_s, last_pix_s;
  logic [9:0]     pos_x_s;
  logic [8:0]     pos_y_s;
  logic           on_screen_s;
  logic [3:0]     rom_sel_r, rom_sel_nx;
  logic           pix_valid_r, pix_valid_nx, pix_key_r, pix_key_nx;
  logic [8:0]     pix_x_r, pix_x_nx;
  logic [7:0]     pix_y_r, pix_y_nx;

  // Queue bookkeeping. Readiness is registered, so a pop in the same cycle
  // never frees a slot for a push in that cycle.
  assign job_in_s     = '{x: jobBus.iJobX, y: jobBus.iJobY, w: jobBus.iJobW,
                          h: jobBus.iJobH, src: jobBus.iJobSrc};
  assign head_s       = fifo_mem_r[rd_ptr_r[PTR_W-1:0]];
  assign push_s       = jobBus.iJobValid && job_ready_r;
  assign wr_ptr_nx    = push_s ? wr_ptr_r + PTR_ONE : wr_ptr_r;
  assign rd_ptr_nx    = pop_s ? rd_ptr_r + PTR_ONE : rd_ptr_r;
  assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
  assign last_one_s   = ((wr_ptr_r - rd_ptr_r) == PTR_ONE);
  assign full_nx_s    = (wr_ptr_nx[PTR_W] != rd_ptr_nx[PTR_W]) &&
                        (wr_ptr_nx[PTR_W-1:0] == rd_ptr_nx[PTR_W-1:0]);
  assign vsync_fall_s = vsync_prev_r && !iVSync;

  // Raster walk shared by background and sprites; the address simply counts,
  // which keeps it equal to v*W + u without a multiplier.
  assign row_last_s  = (state_r == S_BG) ? LAST_X : {3'b000, job_w_r - 6'd1};
  assign col_last_s  = (state_r == S_BG) ? LAST_Y : {2'b00, job_h_r - 6'd1};
  assign row_end_s   = (u_r == row_last_s);
  assign last_pix_s  = row_end_s && (v_r == col_last_s);
  assign u_step_s    = row_end_s ? 9'd0 : u_r + 9'd1;
  assign v_step_s    = row_end_s ? v_r + 8'd1 : v_r;
  assign addr_step_s = addr_r + 17'd1;

  // Sprite screen position is widened by one bit so it cannot wrap back on-screen.
  assign pos_x_s     = {1'b0, job_x_r} + {1'b0, u_r};
  assign pos_y_s     = {1'b0, job_y_r} + {1'b0, v_r};
  assign on_screen_s = (pos_x_s < SCREEN_W_L) && (pos_y_s < SCREEN_H_L);

  // Next-state, raster counters and pipeline-stage inputs.
  always_comb begin
    state_nx     = state_r;
    addr_nx      = addr_r;
    u_nx         = u_r;
    v_nx         = v_r;
    pop_s        = 1'b0;
    rom_sel_nx   = 4'd0;
    pix_valid_nx = 1'b0;
    pix_x_nx     = 9'd0;
    pix_y_nx     = 8'd0;
    pix_key_nx   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (vsync_fall_s) begin
          state_nx = S_BG;
          addr_nx  = 17'd0;
          u_nx     = 9'd0;
          v_nx     = 8'd0;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_BG: begin
        addr_nx      = addr_step_s;
        u_nx         = u_step_s;
        v_nx         = v_step_s;
        pix_valid_nx = 1'b1;
        pix_x_nx     = u_r;
        pix_y_nx     = v_r;
        if (last_pix_s) begin
          state_nx = fifo_empty_s ? S_FLUSH : S_LOAD;
        end else begin
          state_nx = S_BG;
        end
      end
      S_LOAD: begin
        pop_s   = 1'b1;
        addr_nx = 17'd0;
        u_nx    = 9'd0;
        v_nx    = 8'd0;
        // Zero-area jobs are dropped after costing their LOAD cycle.
        if ((head_s.w == 6'd0) || (head_s.h == 6'd0)) begin
          state_nx = last_one_s ? S_FLUSH : S_LOAD;
        end else begin
          state_nx   = S_SPRITE;
          rom_sel_nx = head_s.src;
        end
      end
      S_SPRITE: begin
        addr_nx      = addr_step_s;
        u_nx         = u_step_s;
        v_nx         = v_step_s;
        pix_valid_nx = on_screen_s;
        pix_x_nx     = pos_x_s[8:0];
        pix_y_nx     = pos_y_s[7:0];
        pix_key_nx   = 1'b1;
        if (last_pix_s) begin
          state_nx = fifo_empty_s ? S_FLUSH : S_LOAD;
        end else begin
          state_nx   = S_SPRITE;
          rom_sel_nx = rom_sel_r;
        end
      end
      S_FLUSH: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State, queue pointers, counters, job registers, pipeline and status flags.
  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state_r      <= S_IDLE;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      vsync_prev_r <= 1'b0;
      job_ready_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      overrun_r    <= 1'b0;
      job_x_r      <= 9'd0;
      job_y_r      <= 8'd0;
      job_w_r      <= 6'd0;
      job_h_r      <= 6'd0;
      addr_r       <= 17'd0;
      u_r          <= 9'd0;
      v_r          <= 8'd0;
      rom_sel_r    <= 4'd0;
      pix_valid_r  <= 1'b0;
      pix_key_r    <= 1'b0;
      pix_x_r      <= 9'd0;
      pix_y_r      <= 8'd0;
    end else begin
      state_r      <= state_nx;
      wr_ptr_r     <= wr_ptr_nx;
      rd_ptr_r     <= rd_ptr_nx;
      vsync_prev_r <= iVSync;
      job_ready_r  <= !full_nx_s;
      busy_r       <= (state_nx != S_IDLE);
      done_r       <= (state_nx == S_FLUSH);
      overrun_r    <= vsync_fall_s && (state_r != S_IDLE);
      if (pop_s) begin
        job_x_r <= head_s.x;
        job_y_r <= head_s.y;
        job_w_r <= head_s.w;
        job_h_r <= head_s.h;
      end
      addr_r       <= addr_nx;
      u_r          <= u_nx;
      v_r          <= v_nx;
      rom_sel_r    <= rom_sel_nx;
      pix_valid_r  <= pix_valid_nx;
      pix_key_r    <= pix_key_nx;
      pix_x_r      <= pix_x_nx;
      pix_y_r      <= pix_y_nx;
    end
  end

  // Queue storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r[PTR_W-1:0]] <= job_in_s;
    end
  end

  assign jobBus.oJobReady = job_ready_r;
  assign oRomSel    = rom_sel_r;
  assign oRomAddr   = addr_r;
  assign oX         = pix_x_r;
  assign oY         = pix_y_r;
  assign oColor     = iRomQ;
  // Only sprite pixels are keyed; the background is drawn as-is.
  assign oWriteEn   = pix_valid_r && !(pix_key_r && (iRomQ == KEY_COLOR));
  assign oBusy      = busy_r;
  assign oFrameDone = done_r;
  assign oOverrun   = overrun_r;
endmodule

// File: tb/tb_frame_draw_scheduler.sv
// tb_frame_draw_scheduler
// Directed bench for frame_draw_scheduler on a reduced 64x48 screen so that
// several whole frames fit in a short run (3072 background pixels, frame
// length 3074 + sum(1 + W*H)). A synchronous one-cycle ROM model drives
// iRomQ; per-ROM-select write statistics are gathered every cycle.
module tb_frame_draw_scheduler;
  localparam int SW = 64;
  localparam int SH = 48;

  logic        clk = 1'b0;
  logic        iResetn;
  logic        iVSync;
  logic [3:0]  oRomSel;
  logic [16:0] oRomAddr;
  logic [2:0]  rom_q;
  logic [8:0]  oX;
  logic [7:0]  oY;
  logic [2:0]  oColor;
  logic        oWriteEn, oBusy, oFrameDone, oOverrun;

  frame_draw_scheduler_if jobBus();

  frame_draw_scheduler #(.SCREEN_W(SW), .SCREEN_H(SH), .DEPTH(4), .KEY_COLOR(3'b111)) dut (
    .clk(clk), .iResetn(iResetn), .iVSync(iVSync), .jobBus(jobBus),
    .oRomSel(oRomSel), .oRomAddr(oRomAddr), .iRomQ(rom_q),
    .oX(oX), .oY(oY), .oColor(oColor), .oWriteEn(oWriteEn),
    .oBusy(oBusy), .oFrameDone(oFrameDone), .oOverrun(oOverrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ROM contents: background = low address bits (includes the key colour);
  // select 9 / 11 return the key colour on even u for widths 5 / 4.
  function automatic logic [2:0] rom_f(input logic [3:0] sel, input logic [16:0] a);
    if (sel == 4'd0)  return a[2:0];
    if (sel == 4'd9)  return ((a % 17'd5) % 17'd2 == 17'd0) ? 3'b111 : 3'b010;
    if (sel == 4'd11) return ((a % 17'd4) % 17'd2 == 17'd0) ? 3'b111 : 3'b010;
    return 3'b010;
  endfunction

  logic [3:0]  sel_d;
  logic [16:0] addr_d;
  always @(posedge clk) begin
    rom_q  <= rom_f(oRomSel, oRomAddr);
    sel_d  <= oRomSel;
    addr_d <= oRomAddr;
  end

  int wr_cnt [16];
  int iss_cnt[16];
  int first_x[16], first_y[16], first_a[16];
  int last_x [16], last_y [16];
  bit seen   [16];
  int out_cnt, color_err, ov_cnt;
  int first_addr, first_busy, frame_len;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One cycle of observation, taken #1 after the rising edge.
  task automatic sample();
    int s;
    if (oOverrun) ov_cnt++;
    if (oRomSel != 4'd0) iss_cnt[oRomSel]++;
    if (oWriteEn) begin
      s = int'(sel_d);
      wr_cnt[s]++;
      if (!seen[s]) begin
        seen[s] = 1'b1; first_x[s] = int'(oX); first_y[s] = int'(oY); first_a[s] = int'(addr_d);
      end
      last_x[s] = int'(oX);
      last_y[s] = int'(oY);
      if (int'(oX) >= SW || int'(oY) >= SH) out_cnt++;
      if (s == 0 && int'(oColor) != ((int'(oY) * SW + int'(oX)) & 7)) color_err++;
    end
  endtask

  // Drops vsync, runs until oFrameDone (bounded), then raises vsync again.
  // The sample cycle itself counts as cycle 1 of the frame length.
  task automatic run_frame(input int glitch_at);
    int  n;
    bit  done;
    for (int i = 0; i < 16; i++) begin
      wr_cnt[i] = 0; iss_cnt[i] = 0; seen[i] = 1'b0;
      first_x[i] = -1; first_y[i] = -1; first_a[i] = -1; last_x[i] = -1; last_y[i] = -1;
    end
    out_cnt = 0; color_err = 0; ov_cnt = 0;
    iVSync = 1'b0;
    n = 0;
    done = 1'b0;
    while (!done && n < 20000) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin first_addr = int'(oRomAddr); first_busy = int'(oBusy); end
      sample();
      if (glitch_at != 0 && n == glitch_at) iVSync = 1'b1;
      if (glitch_at != 0 && n == glitch_at + 1) iVSync = 1'b0;
      done = oFrameDone;
    end
    check("frame_done_seen", int'(done), 1);
    frame_len = n + 1;
    iVSync = 1'b1;
    @(posedge clk); #1;
    check("idle_after_frame", int'(oBusy), 0);
  endtask

  task automatic push_job(input logic [8:0] x, input logic [7:0] y, input logic [5:0] w,
                          input logic [5:0] h, input logic [3:0] src);
    int n;
    jobBus.iJobX = x; jobBus.iJobY = y; jobBus.iJobW = w; jobBus.iJobH = h;
    jobBus.iJobSrc = src;
    jobBus.iJobValid = 1'b1;
    n = 0;
    while (!jobBus.oJobReady && n < 50) begin @(posedge clk); #1; n++; end
    check("push_ready", int'(jobBus.oJobReady), 1);
    @(posedge clk); #1;
    jobBus.iJobValid = 1'b0;
  endtask

  initial begin
    iResetn = 1'b0;
    iVSync  = 1'b1;
    jobBus.iJobValid = 1'b0;
    jobBus.iJobX = 9'd0; jobBus.iJobY = 8'd0; jobBus.iJobW = 6'd0; jobBus.iJobH = 6'd0;
    jobBus.iJobSrc = 4'd0;
    #2;
    check("rst_ready", int'(jobBus.oJobReady), 0);
    check("rst_busy", int'(oBusy), 0);
    check("rst_addr", int'(oRomAddr), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) iResetn = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", int'(jobBus.oJobReady), 1);

    // Reset in the middle of the background pass.
    iVSync = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("midbg_busy_before", int'(oBusy), 1);
    iResetn = 1'b0;
    #1;
    check("midbg_rst_busy", int'(oBusy), 0);
    check("midbg_rst_addr", int'(oRomAddr), 0);
    check("midbg_rst_x", int'(oX), 0);
    check("midbg_rst_y", int'(oY), 0);
    check("midbg_rst_we", int'(oWriteEn), 0);
    check("midbg_rst_sel", int'(oRomSel), 0);
    check("midbg_rst_done", int'(oFrameDone), 0);
    check("midbg_rst_ovr", int'(oOverrun), 0);
    check("midbg_rst_ready", int'(jobBus.oJobReady), 0);
    iVSync = 1'b1;
    @(negedge clk) iResetn = 1'b1;
    @(posedge clk); #1;

    // Empty queue: background only.
    run_frame(0);
    check("bg_first_addr", first_addr, 0);
    check("bg_first_busy", first_busy, 1);
    check("bg_writes", wr_cnt[0], 3072);
    check("bg_first_x", first_x[0], 0);
    check("bg_first_y", first_y[0], 0);
    check("bg_last_x", last_x[0], 63);
    check("bg_last_y", last_y[0], 47);
    check("bg_color_align", color_err, 0);
    check("bg_len", frame_len, 3074);
    check("bg_overrun", ov_cnt, 0);

    // Two adjacent 17x17 sprites.
    push_job(9'd20, 8'd10, 6'd17, 6'd17, 4'd3);
    push_job(9'd37, 8'd10, 6'd17, 6'd17, 4'd4);
    run_frame(0);
    check("sp_bg_writes", wr_cnt[0], 3072);
    check("sp3_writes", wr_cnt[3], 289);
    check("sp4_writes", wr_cnt[4], 289);
    check("sp3_first_x", first_x[3], 20);
    check("sp3_first_y", first_y[3], 10);
    check("sp3_first_addr", first_a[3], 0);
    check("sp4_last_x", last_x[4], 53);
    check("sp4_last_y", last_y[4], 26);
    check("sp_len", frame_len, 3654);

    // Clipping at the right/bottom edge and near the 9/8-bit wrap points.
    push_job(9'd58, 8'd44, 6'd16, 6'd8, 4'd5);
    push_job(9'd500, 8'd5, 6'd20, 6'd2, 4'd6);
    push_job(9'd5, 8'd250, 6'd2, 6'd10, 4'd8);
    run_frame(0);
    check("clip_issued", iss_cnt[5], 128);
    check("clip_writes", wr_cnt[5], 24);
    check("clip_last_x", last_x[5], 63);
    check("clip_last_y", last_y[5], 47);
    check("wrapx_issued", iss_cnt[6], 40);
    check("wrapx_writes", wr_cnt[6], 0);
    check("wrapy_writes", wr_cnt[8], 0);
    check("clip_out_of_screen", out_cnt, 0);
    check("clip_len", frame_len, 3265);

    // Colour keying, and a zero-width job between two keyed sprites.
    push_job(9'd10, 8'd10, 6'd5, 6'd3, 4'd9);
    push_job(9'd0, 8'd0, 6'd0, 6'd4, 4'd10);
    push_job(9'd30, 8'd20, 6'd4, 6'd2, 4'd11);
    run_frame(0);
    check("key9_writes", wr_cnt[9], 6);
    check("key9_first_x", first_x[9], 11);
    check("key9_first_y", first_y[9], 10);
    check("w0_issued", iss_cnt[10], 0);
    check("w0_writes", wr_cnt[10], 0);
    check("key11_writes", wr_cnt[11], 4);
    check("key11_last_x", last_x[11], 33);
    check("key11_last_y", last_y[11], 21);
    check("key_bg_unkeyed", wr_cnt[0], 3072);
    check("key_len", frame_len, 3100);

    // Queue full, fifth push held off; vsync edge while busy.
    push_job(9'd0, 8'd0, 6'd2, 6'd2, 4'd12);
    push_job(9'd2, 8'd0, 6'd2, 6'd2, 4'd13);
    push_job(9'd4, 8'd0, 6'd2, 6'd2, 4'd14);
    push_job(9'd6, 8'd0, 6'd2, 6'd2, 4'd15);
    check("full_ready_low", int'(jobBus.oJobReady), 0);
    jobBus.iJobX = 9'd8; jobBus.iJobY = 8'd0; jobBus.iJobW = 6'd2; jobBus.iJobH = 6'd2;
    jobBus.iJobSrc = 4'd6;
    jobBus.iJobValid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("full_held_off", int'(jobBus.oJobReady), 0);
    jobBus.iJobValid = 1'b0;
    run_frame(200);
    check("ovr_pulses", ov_cnt, 1);
    check("ovr_len", frame_len, 3094);
    check("ovr_job12", wr_cnt[12], 4);
    check("ovr_job15", wr_cnt[15], 4);
    check("fifth_not_queued", wr_cnt[6], 0);
    check("ovr_bg_writes", wr_cnt[0], 3072);
    check("ready_after_drain", int'(jobBus.oJobReady), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
